// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver feeding a show-ahead FIFO; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            UART_TXD_IN,
  input  logic                            rd_en,
  output logic [DATA_BITS-1:0]            rd_data,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            frame_err,
  output logic                            overrun,
  output logic                            parity_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [15:0] HALF_T = 16'(CLKS_PER_BIT/2 - 1);
  localparam logic [15:0] BIT_T  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST   = 3'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [2:0] sync_q;
  logic [15:0] tmr_q, tmr_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic perr_q, perr_d;
  logic ferr_q, ovr_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic rx, fall, tick, stop_hit, push, wr, rd;
  assign rx       = sync_q[1];
  assign fall     = sync_q[2] & ~sync_q[1];
  assign tick     = tmr_q == '0;
  assign stop_hit = state_q == STOP && tick;
  assign push     = stop_hit & rx & ~perr_q;
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == CW'(FIFO_DEPTH);
  assign wr       = push & (~full | rd_en);
  assign rd       = rd_en & ~empty;
  assign count    = cnt_q;
  assign rd_data  = mem_q[rp_q];
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  // next-state: every sample is taken when the down-counter reaches zero, then it is reloaded to one bit time
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q - 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        tmr_d  = HALF_T;
        bit_d  = '0;
        perr_d = 1'b0;
        if (fall) state_d = START;
      end
      START: if (tick) begin
        tmr_d   = BIT_T;
        state_d = rx ? IDLE : DATA;
      end
      DATA: if (tick) begin
        tmr_d = BIT_T;
        sh_d  = {rx, sh_q[DATA_BITS-1:1]};
        bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == LAST) state_d = PARITY;
`else
        if (bit_q == LAST) state_d = STOP;
`endif
      end
      PARITY: if (tick) begin
        tmr_d   = BIT_T;
`ifdef UART_RX_PARITY_EN
        perr_d  = ^{rx, sh_q};
`endif
        state_d = STOP;
      end
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // control state, synchroniser, FIFO bookkeeping and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '1;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], UART_TXD_IN};
      ferr_q  <= stop_hit & ~rx;
      ovr_q   <= push & full & ~rd_en;
      wp_q    <= wp_q + AW'(wr);
      rp_q    <= rp_q + AW'(rd);
      cnt_q   <= cnt_q + CW'(wr) - CW'(rd);
    end
  end
  // datapath: bit timer, shifter and storage need no reset since IDLE reloads them
  always_ff @(posedge clk) begin
    tmr_q  <= tmr_d;
    bit_q  <= bit_d;
    sh_q   <= sh_d;
    perr_q <= perr_d;
    if (wr) mem_q[wp_q] <= sh_q;
  end
`ifdef UART_RX_PARITY_EN
  logic pe_q;
  // parity error pulse lines up with the stop-bit sample, alongside any frame error
  always_ff @(posedge clk) pe_q <= rst ? 1'b0 : stop_hit & perr_q;
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames checked against a queue model of the receive FIFO
module tb_uart_rx_fifo;
  localparam int CPB = 16, DB = 8, DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, rd_en = 1'b0;
  logic [DB-1:0] rd_data;
  logic empty, full, frame_err, overrun, parity_err;
  logic [2:0] count;
  int checks = 0, errors = 0;
  int fe_n = 0, ov_n = 0, pe_n = 0, exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic [DB-1:0] q [$];
  logic [DB-1:0] d;
`ifdef UART_RX_PARITY_EN
  logic pflip = 1'b0;
`endif
  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .UART_TXD_IN(rxd), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) fe_n++;
    if (overrun) ov_n++;
    if (parity_err) pe_n++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic send_bit(input logic v);
    rxd = v;
    tk(CPB);
  endtask
  task automatic head(input logic [DB-1:0] v);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(v[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^v ^ pflip);
`endif
  endtask
  task automatic mpush(input logic [DB-1:0] v);
    if (q.size() < DEPTH) q.push_back(v);
    else exp_ov++;
  endtask
  task automatic send(input logic [DB-1:0] v);
    head(v);
    send_bit(1'b1);
    mpush(v);
    chk("send_cnt", count, q.size());
  endtask
  task automatic send_timed(input logic [DB-1:0] v, input logic pop);
    head(v);
    rxd = 1'b1;
    tk(10);
    chk("pre_cnt", count, q.size());
    if (pop) chk("pre_head", rd_data, q[0]);
    rd_en = pop;
    tk(1);
    rd_en = 1'b0;
    if (pop) void'(q.pop_front());
    mpush(v);
    chk("cnt", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("overrun", ov_n, exp_ov);
    if (q.size() > 0) chk("head", rd_data, q[0]);
    tk(5);
  endtask
  task automatic pop_chk();
    chk("pop_data", rd_data, q[0]);
    rd_en = 1'b1;
    tk(1);
    rd_en = 1'b0;
    void'(q.pop_front());
    chk("pop_cnt", count, q.size());
  endtask
  initial begin
    tk(4);
    chk("rst_cnt", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pulses", {frame_err, overrun, parity_err}, 0);
    rst = 1'b0;
    tk(5);
    send_timed(8'hA5, 1'b0);
    chk("a5_data", rd_data, 8'hA5);
    pop_chk();
    rd_en = 1'b1;
    tk(3);
    rd_en = 1'b0;
    chk("rd_empty_cnt", count, 0);
    chk("rd_empty_flag", empty, 1);
    for (int i = 1; i <= 4; i++) send(DB'(i));
    send_timed(8'h05, 1'b0);
    chk("ovr_once", ov_n, 1);
    while (q.size() > 0) pop_chk();
    chk("drained", empty, 1);
    head(8'h3C);
    send_bit(1'b0);
    rxd = 1'b1;
    tk(CPB);
    exp_fe++;
    chk("ferr_pulse", fe_n, exp_fe);
    chk("ferr_cnt", count, 0);
    rxd = 1'b0;
    tk(3);
    rxd = 1'b1;
    tk(3 * CPB);
    chk("glitch_cnt", count, 0);
    chk("glitch_ferr", fe_n, exp_fe);
    send(8'h5A);
    pop_chk();
    for (int i = 0; i < DEPTH; i++) send(DB'($urandom));
    send_timed(DB'($urandom), 1'b1);
    pop_chk();
    pop_chk();
    send_timed(DB'($urandom), 1'b1);
    while (q.size() > 0) pop_chk();
    for (int n = 0; n < 12; n++) begin
      d = DB'($urandom);
      send_timed(d, q.size() > 0 && $urandom_range(1, 0) == 1);
      if ($urandom_range(3, 0) == 0) while (q.size() > 0) pop_chk();
    end
    while (q.size() > 0) pop_chk();
    send(DB'($urandom));
    send(DB'($urandom));
    chk("pre_rst_cnt", count, 2);
    d = DB'($urandom) | DB'(8'h10);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rxd = d[4];
    tk(CPB / 2);
    rst = 1'b1;
    tk(1);
    rst = 1'b0;
    rxd = 1'b1;
    q.delete();
    chk("midrst_cnt", count, 0);
    chk("midrst_empty", empty, 1);
    tk(12 * CPB);
    chk("midrst_idle_cnt", count, 0);
    chk("midrst_pulses", fe_n + ov_n + pe_n, exp_fe + exp_ov + exp_pe);
    send(8'hC3);
    pop_chk();
`ifdef UART_RX_PARITY_EN
    pflip = 1'b1;
    send_bit(1'b1);
    head(8'h07);
    send_bit(1'b1);
    exp_pe++;
    chk("perr_pulse", pe_n, exp_pe);
    chk("perr_cnt", count, 0);
    pflip = 1'b0;
    send(8'h07);
    pop_chk();
`endif
    chk("frame_err_total", fe_n, exp_fe);
    chk("overrun_total", ov_n, exp_ov);
    chk("parity_err_total", pe_n, exp_pe);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (115200 baud at 100 MHz); legal range 4 to 65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame; legal range 5 to 8.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of receive FIFO entries; legal values are powers of 2 from 2 to 256.
REQ-004 The block SHALL have port clk, input, width 1: the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port UART_TXD_IN, input, width 1: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rd_en, input, width 1: pop request.
REQ-008 The block SHALL have port rd_data, output, width DATA_BITS: FIFO head, show-ahead.
REQ-009 The block SHALL have port empty, output, width 1: FIFO holds 0 entries.
REQ-010 The block SHALL have port full, output, width 1: FIFO holds FIFO_DEPTH entries.
REQ-011 The block SHALL have port count, output, width $clog2(FIFO_DEPTH+1): current number of FIFO entries.
REQ-012 The block SHALL have port frame_err, output, width 1: one-cycle pulse when a frame's stop bit is sampled low.
REQ-013 The block SHALL have port overrun, output, width 1: one-cycle pulse when a valid frame is dropped because the FIFO is full.
REQ-014 The block SHALL have port parity_err, output, width 1: one-cycle pulse when a parity mismatch is detected.

Function
REQ-015 UART_TXD_IN SHALL pass through a 2-flop synchroniser; all FSM decisions SHALL use the synchronised value.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-017 IDLE -> START on a synchronised 1-to-0 transition; the bit counter SHALL be loaded so the first sample falls CLKS_PER_BIT/2 (floor) cycles later.
REQ-018 In START, a sample of 1 (glitch) SHALL return the FSM to IDLE with no push and no error.
REQ-019 In START, a sample of 0 SHALL move the FSM to DATA.
REQ-020 In DATA, DATA_BITS samples SHALL be taken CLKS_PER_BIT apart at mid-bit and assembled LSB first.
REQ-021 After the last data bit, the FSM SHALL go to PARITY when UART_RX_PARITY_EN is defined, otherwise to STOP.
REQ-022 STOP SHALL sample once at mid-bit and then return to IDLE in the same cycle, with no wait for the end of the stop bit, so back-to-back frames are accepted.
REQ-023 On a stop sample of 1 with no parity error, the byte SHALL be pushed on the next clk edge; empty SHALL deassert and count SHALL increment in that same cycle.
REQ-024 On a stop sample of 0, the byte SHALL be discarded and frame_err SHALL pulse for 1 cycle.
REQ-025 When a push occurs with full=1 and rd_en=0, the new byte SHALL be dropped, the FIFO SHALL remain unchanged and overrun SHALL pulse for 1 cycle.
REQ-026 When a push occurs with full=1 and rd_en=1 in the same cycle, the pop and the push SHALL both complete, and count SHALL stay at FIFO_DEPTH.
REQ-027 rd_en with empty=1 SHALL be ignored: pointers and count unchanged, no error.
REQ-028 A push and a pop in the same cycle with 0 < count < FIFO_DEPTH SHALL leave count unchanged.
REQ-029 rd_data SHALL equal the head entry whenever empty=0, and SHALL be don't-care whenever empty=1.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 Error pulses SHALL never be asserted together with a push of the same frame.

Reset
REQ-032 While rst=1 at a rising edge, the FSM SHALL go to IDLE, and the synchroniser flops SHALL be set to 1.
REQ-033 While rst=1 at a rising edge, the pointers and count SHALL be set to 0.
REQ-034 While rst=1 at a rising edge, empty SHALL be set to 1 and full to 0.
REQ-035 While rst=1 at a rising edge, frame_err, overrun and parity_err SHALL be set to 0.
REQ-036 Reset asserted in mid-frame SHALL abandon the partial frame with no push and no error pulse.
REQ-037 After reset, the FSM SHALL wait in IDLE for a fresh falling edge.
REQ-038 FIFO storage contents SHALL NOT need to be reset.

Configuration
REQ-039 With UART_RX_PARITY_EN defined, the FSM SHALL take one even-parity sample in the PARITY state.
REQ-040 With UART_RX_PARITY_EN defined, a mismatch SHALL discard the byte and pulse parity_err for 1 cycle.
REQ-041 With UART_RX_PARITY_EN defined, if the stop bit is also low, frame_err SHALL pulse together with parity_err.
REQ-042 Without UART_RX_PARITY_EN, the PARITY state SHALL be unreachable and parity_err SHALL be tied to 0.

Verification
REQ-043 With CLKS_PER_BIT=16 and no parity, send frame 0xA5 -> 1 cycle after the stop mid-sample: empty=0, count=1, rd_data=0xA5.
REQ-044 With FIFO_DEPTH=4, send 0x01 to 0x05 back to back with no reads -> count=4, full=1, overrun pulses once on 0x05; pop 4 times returns 0x01 to 0x04 in order.
REQ-045 Send 0x3C with a low stop bit -> frame_err pulses 1 cycle, count stays 0.
REQ-046 Drive a 0 on UART_TXD_IN for 3 cycles only -> FSM returns to IDLE, no push, no error; a following 0x5A is received correctly.
REQ-047 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err pulses, no push; the same frame with parity bit 1 -> pushed.
REQ-048 Assert rst for 1 cycle during data bit 4 of a frame, with count=2 -> count=0, empty=1, no pulses; the next full frame is received correctly.
